// File: rtl/adder_i4_o3_wce2_pkg.sv
// rtl/adder_i4_o3_wce2_pkg.sv - shared widths and approximate-sum function for the 2+2 bit adder cell
package adder_i4_o3_wce2_pkg;

  localparam int IN_W       = 4;
  localparam int OUT_W      = 3;
  localparam int WCE_BUDGET = 2;

  // LSB carry is dropped: the sum bit 0 becomes an OR, the MSBs form a half-adder.
  function automatic logic [OUT_W-1:0] approx_sum(input logic [1:0] a, input logic [1:0] b);
    logic [OUT_W-1:0] s;
    s[0] = a[0] | b[0];
    s[1] = a[1] ^ b[1];
    s[2] = a[1] & b[1];
    return s;
  endfunction

endpackage

// File: rtl/adder_i4_o3_wce2_comb.sv
// rtl/adder_i4_o3_wce2_comb.sv - combinational approximate 2-bit + 2-bit adder
module adder_i4_o3_wce2_comb
  import adder_i4_o3_wce2_pkg::*;
(
  input  logic pi3,
  input  logic pi2,
  input  logic pi1,
  input  logic pi0,
  output logic po2,
  output logic po1,
  output logic po0
);

  logic [IN_W-1:0]  pi;
  logic [OUT_W-1:0] s;

  assign pi = {pi3, pi2, pi1, pi0};
  assign s  = approx_sum(pi[3:2], pi[1:0]);

  assign po2 = s[2];
  assign po1 = s[1];
  assign po0 = s[0];

endmodule

// File: rtl/adder_i4_o3_wce2.sv
// rtl/adder_i4_o3_wce2.sv - registered approximate adder, one-cycle latency, async active-high reset
module adder_i4_o3_wce2
  import adder_i4_o3_wce2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pi3,
  input  logic pi2,
  input  logic pi1,
  input  logic pi0,
  output logic po2,
  output logic po1,
  output logic po0
);

  logic [OUT_W-1:0] sum_d;
  logic [OUT_W-1:0] sum_q;

  adder_i4_o3_wce2_comb u_comb (
    .pi3 (pi3),
    .pi2 (pi2),
    .pi1 (pi1),
    .pi0 (pi0),
    .po2 (sum_d[2]),
    .po1 (sum_d[1]),
    .po0 (sum_d[0])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign po2 = sum_q[2];
  assign po1 = sum_q[1];
  assign po0 = sum_q[0];

endmodule

// File: tb/tb_adder_i4_o3_wce2.sv
// tb/tb_adder_i4_o3_wce2.sv - self-checking bench for the registered approximate adder
module tb_adder_i4_o3_wce2;
  import adder_i4_o3_wce2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pi3 = 1'b0, pi2 = 1'b0, pi1 = 1'b0, pi0 = 1'b0;
  logic po2, po1, po0;
  logic [2:0] po;

  int checks = 0;
  int errors = 0;

  adder_i4_o3_wce2 dut (
    .clk (clk),
    .rst (rst),
    .pi3 (pi3),
    .pi2 (pi2),
    .pi1 (pi1),
    .pi0 (pi0),
    .po2 (po2),
    .po1 (po1),
    .po0 (po0)
  );

  always #5 clk = ~clk;
  assign po = {po2, po1, po0};

  // Exact sum, less one whenever both operand LSBs are set (the dropped carry).
  function automatic logic [2:0] ref_sum(input logic [3:0] v);
    int a, b, ex;
    a  = int'(v[3:2]);
    b  = int'(v[1:0]);
    ex = a + b;
    if ((a % 2 == 1) && (b % 2 == 1)) ex = ex - 1;
    return 3'(ex);
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {pi3, pi2, pi1, pi0} = v;
  endtask

  // Drive at the falling edge, check 1 time unit after the following rising edge.
  task automatic step(input logic [3:0] v, input string tag);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    chk(tag, po, ref_sum(v));
  endtask

  logic [3:0] sweep [16] = '{4'b0000, 4'b0010, 4'b0001, 4'b0011,
                             4'b1000, 4'b1010, 4'b1001, 4'b1011,
                             4'b0100, 4'b0110, 4'b0101, 4'b0111,
                             4'b1100, 4'b1110, 4'b1101, 4'b1111};
  logic [2:0] sweep_exp [16] = '{3'b000, 3'b010, 3'b001, 3'b011,
                                 3'b010, 3'b100, 3'b011, 3'b101,
                                 3'b001, 3'b011, 3'b001, 3'b011,
                                 3'b011, 3'b101, 3'b011, 3'b101};

  initial begin
    drive(4'b1111);
    #2;
    chk("reset_no_edge", po, 3'b000);
    @(negedge clk);
    chk("reset_held", po, 3'b000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("first_after_reset", po, 3'b101);

    for (int i = 0; i < 16; i++) begin
      int a, b, err;
      @(negedge clk);
      drive(sweep[i]);
      @(posedge clk);
      #1;
      chk($sformatf("sweep_%b", sweep[i]), po, sweep_exp[i]);
      chk($sformatf("model_%b", sweep[i]), po, ref_sum(sweep[i]));
      a   = int'(sweep[i][3:2]);
      b   = int'(sweep[i][1:0]);
      err = a + b - int'(po);
      checks++;
      assert (err >= 0 && err < WCE_BUDGET && err == ((a & b) & 1)) else begin
        errors++;
        $error("FAIL err_%b observed=%0d expected=%0d", sweep[i], err, (a & b) & 1);
      end
    end

    step(4'b0000, "lat_zero");
    @(negedge clk);
    drive(4'b1010);
    chk("lat_hold", po, 3'b000);
    @(posedge clk);
    #1;
    chk("lat_update", po, 3'b100);

    for (int i = 0; i < 8; i++) begin
      step((i % 2 == 0) ? 4'b1111 : 4'b0000, $sformatf("toggle_%0d", i));
    end

    step(4'b1011, "mid_pre0");
    step(4'b1111, "mid_pre1");
    #2;
    rst = 1'b1;
    #1;
    chk("mid_reset_async", po, 3'b000);
    @(posedge clk);
    #1;
    chk("mid_reset_edge1", po, 3'b000);
    @(posedge clk);
    #1;
    chk("mid_reset_edge2", po, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    drive(4'b0110);
    @(posedge clk);
    #1;
    chk("after_mid_reset", po, 3'b011);

    for (int i = 0; i < 64; i++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15));
      step(v, $sformatf("rand_%0d_%b", i, v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
